pipelined_block_adder_core: RTL and testbench
=============================================

// Module: pipelined_block_adder_core
// PURPOSE
//  Fully pipelined WIDTH-bit adder: sum = a + b + cin (mod 2^WIDTH).
//  Carry chain is split into BLOCK-bit slices with one register stage per slice.
//  Sustains one operation per clock with fixed latency and no back-pressure.
//  Used as the timing-friendly sum core of the ALU datapath.
// PARAMETERS
//  WIDTH  32  operand/result width in bits
//  BLOCK  4   bits per pipeline slice; WIDTH % BLOCK must be 0
// PORTS
//  clk    in   1      single clock, rising edge
//  rst    in   1      synchronous, active-high reset
//  v_in   in   1      input valid: a/b/cin sampled this edge
//  a      in   WIDTH  operand A
//  b      in   WIDTH  operand B
//  cin    in   1      carry-in into bit 0
//  sum    out  WIDTH  result, meaningful only when v_out=1
//  v_out  out  1      result valid
// BEHAVIOUR
//  - NSTAGES = WIDTH/BLOCK. Latency = NSTAGES cycles: an operation sampled
//    with v_in=1 at edge N appears with v_out=1 after edge N+NSTAGES-1.
//    That is, v_out is asserted in the cycle following that edge.
//  - Stage k (0..NSTAGES-1) adds slice k, bits [k*BLOCK +: BLOCK], of the
//    input-skewed operands. Stage 0 uses cin; stage k>0 uses the registered
//    carry-out of stage k-1.
//  - Input skew: slice k of a/b is delayed k cycles before use.
//  - Output deskew: the result of slice k is delayed NSTAGES-1-k cycles so all
//    slices of one operation reach sum together.
//  - Throughput: one operation per cycle; back-to-back v_in=1 is legal.
//    No stall or ready signal exists.
//  - Valid shift register, NSTAGES deep, carries v_in; v_out is its last bit.
//  - Bubbles (v_in=0) propagate as v_out=0, in order.
//  - a/b/cin are don't-care (may be X) while v_in=0.
//  - Every data register loads only when its stage-valid bit is 1. X inputs
//    during bubbles therefore never reach sum.
//  - While v_out=0, sum holds its last valid value.
//  - Overflow wraps silently: all-ones + 1 = 0.
//  - Results emerge strictly in input order; none are dropped or duplicated.
//  - Reset (synchronous, rst=1 at an edge):
//      - clears all valid bits, sum=0 and all data registers;
//      - in-flight operations are discarded, including those mid-pipeline;
//      - v_in is ignored while rst=1.
//    The first v_in=1 after rst deasserts yields v_out NSTAGES cycles later.
//  - Elaboration error ($error/$fatal) if WIDTH % BLOCK != 0 or BLOCK < 1.
//  - BLOCK == WIDTH is legal: single stage, latency 1.
// CONFIGURATION
//  PIPELINED_ADDER_COUT_EN
//    defined: adds output port cout (1 bit), the carry-out of bit WIDTH-1.
//      cout is aligned with sum/v_out and has the same hold and reset rules.
//    undefined: no cout port; the final carry is discarded.
// TESTING  (WIDTH=32, BLOCK=4, latency 8)
//  - Zero: a=0,b=0,cin=0 -> 8 cycles later v_out=1, sum=0x00000000.
//  - Wrap: a=0xFFFFFFFF,b=0,cin=1 -> sum=0x00000000; a=0xFFFFFFFF,b=1,cin=0 -> 0x00000000 (cout=1 if EN).
//  - Slice boundaries: for k=4,8..28, a=2^k-1,b=1,cin=0 -> sum=2^k; back-to-back issue, in order.
//  - Streaming: 2000 random back-to-back ops -> each sum == a+b+cin, exact count, no extra v_out.
//  - Bubbles: alternate v_in=1/0 with X on a/b/cin when idle -> v_out follows v_in pattern delayed 8, no X on sum.
//  - Reset mid-stream: assert rst with 5 ops in flight -> v_out=0,sum=0 next cycle; none of the 5 emerge.

Source files
------------

// File: rtl/pipelined_block_adder_core.sv
// Pipelined block-carry adder: sum = a + b + cin (mod 2^WIDTH), one BLOCK-bit carry slice per register stage.
// Define PIPELINED_ADDER_COUT_EN to add the cout port (carry-out of bit WIDTH-1, aligned with sum).
module pipelined_block_adder_core #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             v_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_ADDER_COUT_EN
    output logic             cout,
`endif
    output logic             v_out
);
    localparam int NSTAGES = (BLOCK > 0) ? WIDTH / BLOCK : 1;
    localparam int NSKEW   = (NSTAGES > 1) ? NSTAGES - 1 : 1;

    if (BLOCK < 1) begin : g_bad_block
        $error("pipelined_block_adder_core: BLOCK must be at least 1");
    end else if (WIDTH % BLOCK != 0) begin : g_bad_width
        $error("pipelined_block_adder_core: WIDTH must be a multiple of BLOCK");
    end

    logic [NSTAGES-1:0] stage_en;
    logic [NSTAGES-1:0] v_pipe;
    logic [WIDTH-1:0]   a_skew [NSKEW];
    logic [WIDTH-1:0]   b_skew [NSKEW];
    logic               carry  [NSTAGES];
    logic [WIDTH-1:0]   res    [NSTAGES];

    // stage_en[k] is the valid bit of the operation about to be loaded into stage k
    assign stage_en = (v_pipe << 1) | NSTAGES'(v_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            v_pipe <= '0;
        end else begin
            v_pipe <= stage_en;
        end
    end

    for (genvar j = 0; j < NSTAGES; j++) begin : g_stage
        logic [BLOCK-1:0] op_a;
        logic [BLOCK-1:0] op_b;
        logic             c_in;
        logic [WIDTH-1:0] res_prev;
        logic [BLOCK:0]   s;

        if (j == 0) begin : g_head
            assign op_a     = a[BLOCK-1:0];
            assign op_b     = b[BLOCK-1:0];
            assign c_in     = cin;
            assign res_prev = '0;
            if (NSTAGES > 1) begin : g_skew
                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_skew[0] <= '0;
                        b_skew[0] <= '0;
                    end else if (stage_en[0]) begin
                        a_skew[0] <= a >> BLOCK;
                        b_skew[0] <= b >> BLOCK;
                    end
                end
            end
        end else begin : g_body
            assign op_a     = a_skew[j-1][BLOCK-1:0];
            assign op_b     = b_skew[j-1][BLOCK-1:0];
            assign c_in     = carry[j-1];
            assign res_prev = res[j-1];
            // Remaining upper slices shift down one slice per stage so the next slice is always at bit 0
            if (j < NSTAGES - 1) begin : g_skew
                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_skew[j] <= '0;
                        b_skew[j] <= '0;
                    end else if (stage_en[j]) begin
                        a_skew[j] <= a_skew[j-1] >> BLOCK;
                        b_skew[j] <= b_skew[j-1] >> BLOCK;
                    end
                end
            end
        end

        assign s = {1'b0, op_a} + {1'b0, op_b} + {{BLOCK{1'b0}}, c_in};

        // Finished slices enter at the top and shift down, so slice 0 lands at bit 0 in the last stage
        always_ff @(posedge clk) begin
            if (rst) begin
                res[j]   <= '0;
                carry[j] <= 1'b0;
            end else if (stage_en[j]) begin
                res[j]   <= (res_prev >> BLOCK) | (WIDTH'(s[BLOCK-1:0]) << (WIDTH - BLOCK));
                carry[j] <= s[BLOCK];
            end
        end
    end

    assign sum   = res[NSTAGES-1];
    assign v_out = v_pipe[NSTAGES-1];
`ifdef PIPELINED_ADDER_COUT_EN
    assign cout  = carry[NSTAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_block_adder_core.sv
// Self-checking bench for pipelined_block_adder_core (WIDTH=32, BLOCK=4): random and directed
// operations checked against a queue-based model of a + b + cin with an 8-cycle latency.
module tb_pipelined_block_adder_core;
    localparam int WIDTH   = 32;
    localparam int BLOCK   = 4;
    localparam int LATENCY = WIDTH / BLOCK;

    logic             clk;
    logic             rst;
    logic             v_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             v_out;
    logic [WIDTH:0]   dut_res;

`ifdef PIPELINED_ADDER_COUT_EN
    logic cout;
    assign dut_res = {cout, sum};
`else
    assign dut_res = {1'b0, sum};
`endif

    pipelined_block_adder_core #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
        .clk   (clk),
        .rst   (rst),
        .v_in  (v_in),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
`ifdef PIPELINED_ADDER_COUT_EN
        .cout  (cout),
`endif
        .v_out (v_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [WIDTH:0] val;
        int             due;
    } exp_t;

    exp_t           exp_q[$];
    int             cyc       = 0;
    bit             started   = 1'b0;
    bit             rst_edge  = 1'b0;
    logic [WIDTH:0] last_val  = '0;
    int             vectors   = 0;
    int             miscompares = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    // The carry-out bit is only observable when the cout port exists
    function automatic logic [WIDTH:0] visible(input logic [WIDTH:0] v);
`ifdef PIPELINED_ADDER_COUT_EN
        return v;
`else
        return {1'b0, v[WIDTH-1:0]};
`endif
    endfunction

    // Reference model: every accepted operation becomes one expected result due LATENCY-1 edges later
    always @(posedge clk) begin
        started  = 1'b1;
        cyc      = cyc + 1;
        rst_edge = rst;
        if (rst) begin
            exp_q.delete();
        end else if (v_in) begin
            exp_q.push_back('{val: {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin), due: cyc + LATENCY - 1});
        end
    end

    always @(negedge clk) begin
        if (started) begin
            if (rst_edge) begin
                checkOutput("rst_vout", 64'(v_out), 64'd0);
                checkOutput("rst_sum", 64'(dut_res), 64'd0);
                last_val = '0;
            end else if (v_out) begin
                if (exp_q.size() == 0) begin
                    checkOutput("extra_vout", 64'(v_out), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("latency", 64'(cyc), 64'(e.due));
                    checkOutput("sum", 64'(dut_res), 64'(visible(e.val)));
                    last_val = visible(e.val);
                end
            end else begin
                checkOutput("hold_sum", 64'(dut_res), 64'(last_val));
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    checkOutput("missing_vout", 64'(v_out), 64'd1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] ta,
                                 input logic [WIDTH-1:0] tb, input logic tc);
        v_in = v;
        a    = ta;
        b    = tb;
        cin  = tc;
        @(posedge clk);
        #1;
    endtask

    task automatic applyIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 'x, 'x, 1'bx);
    endtask

    task automatic applyRandom();
        applyStimulus(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        logic [WIDTH-1:0] ones;
        ones = '1;
        rst  = 1'b1;
        v_in = 1'b0;
        a    = '0;
        b    = '0;
        cin  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        applyStimulus(1'b1, 32'h0, 32'h0, 1'b0);
        applyIdle(LATENCY + 2);

        applyStimulus(1'b1, ones, 32'h0, 1'b1);
        applyStimulus(1'b1, ones, 32'h1, 1'b0);
        for (int k = 4; k <= 28; k += 4) begin
            applyStimulus(1'b1, (32'h1 << k) - 32'h1, 32'h1, 1'b0);
        end

        for (int i = 0; i < 2000; i++) applyRandom();

        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) applyRandom();
            else applyIdle(1);
        end
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) applyIdle(1);
            else applyRandom();
        end
        applyIdle(LATENCY + 2);

        // Five operations in flight when reset hits; none of them may emerge
        for (int i = 0; i < 5; i++) applyRandom();
        rst = 1'b1;
        applyRandom();
        rst = 1'b0;
        applyIdle(3);
        applyStimulus(1'b1, 32'h1234_5678, 32'h8765_4321, 1'b1);
        applyIdle(2);

        for (int i = 0; i < 40 && exp_q.size() > 0; i++) applyIdle(1);
        applyIdle(3);
        checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
